// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: keypad scanner to seven-segment entry sequencer.
// Accepts key codes over a ready/ack handshake and builds a multi-digit
// entry. Enter commits the entry downstream over a valid/ready handshake.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   key_code, key_ready   scanner key and its request
//   key_ack               one-cycle acknowledge to the scanner
//   disp_data             entry buffer, zero-extended to 16 bits
//   entry_count           digits held in the buffer
//   value, value_valid    committed entry, held until value_ready
//   value_ready           downstream accepts value
//   err                   one-cycle pulse on a rejected key
module keypad_entry_ctrl #(
    parameter int         DIGITS  = 4,
    parameter logic [3:0] KEY_BS  = 4'hE,
    parameter logic [3:0] KEY_ENT = 4'hF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            key_code,
    input  logic                  key_ready,
    output logic                  key_ack,
    output logic [15:0]           disp_data,
    output logic [2:0]            entry_count,
    output logic [4*DIGITS-1:0]   value,
    output logic                  value_valid,
    input  logic                  value_ready,
    output logic                  err
);

    localparam int DW = 4 * DIGITS;

    localparam logic [1:0] S_WAIT    = 2'd0;
    localparam logic [1:0] S_ACK     = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam logic [2:0] MAX_CNT = 3'(DIGITS);

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] buf_q, buf_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [DW-1:0] val_q, val_d;
    logic          vv_q, vv_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;

    logic is_bs;
    logic is_ent;

    assign is_bs  = (key_code == KEY_BS);
    assign is_ent = (key_code == KEY_ENT);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        vv_d    = vv_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;

        // A held value is released by downstream independently of keys.
        if (vv_q && value_ready) begin
            vv_d = 1'b0;
        end

        unique case (state_q)
            S_WAIT: begin
                // Keys stall while a committed value is still pending.
                if (key_ready && !vv_q) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    if (is_bs) begin
                        if (cnt_q != 3'd0) begin
                            buf_d = buf_q >> 4;
                            cnt_d = cnt_q - 3'd1;
                        end
                    end else if (is_ent) begin
                        if (cnt_q != 3'd0) begin
                            val_d = buf_q;
                            vv_d  = 1'b1;
                            buf_d = '0;
                            cnt_d = 3'd0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        if (cnt_q < MAX_CNT) begin
                            buf_d = (buf_q << 4) | DW'(key_code);
                            cnt_d = cnt_q + 3'd1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            S_ACK: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // Ready is still high right after ack; wait for it to drop
                // so one physical press is consumed only once.
                if (!key_ready) begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT;
            buf_q   <= '0;
            cnt_q   <= 3'd0;
            val_q   <= '0;
            vv_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            vv_q    <= vv_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign key_ack     = ack_q;
    assign err         = err_q;
    assign disp_data   = 16'(buf_q);
    assign entry_count = cnt_q;
    assign value       = val_q;
    assign value_valid = vv_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb_keypad_entry_ctrl: scoreboard bench for keypad_entry_ctrl.
// Expected key results are queued at drive time and checked on key_ack.
module tb_keypad_entry_ctrl;

    typedef struct packed {
        logic [15:0] disp;
        logic [2:0]  cnt;
        logic        err;
        logic [15:0] val;
        logic        vv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  key_code;
    logic        key_ready;
    logic        key_ack;
    logic [15:0] disp_data;
    logic [2:0]  entry_count;
    logic [15:0] value;
    logic        value_valid;
    logic        value_ready;
    logic        err;

    int total = 0;
    int bad   = 0;
    int ack_seen = 0;

    exp_t sb[$];

    logic [15:0] m_buf = '0;
    int          m_cnt = 0;
    logic [15:0] m_val = '0;
    logic        m_vv  = 1'b0;

    keypad_entry_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_code    (key_code),
        .key_ready   (key_ready),
        .key_ack     (key_ack),
        .disp_data   (disp_data),
        .entry_count (entry_count),
        .value       (value),
        .value_valid (value_valid),
        .value_ready (value_ready),
        .err         (err)
    );

    always #5 clk = ~clk;

    // Monitor: every ack pops one expected record.
    always @(negedge clk) begin
        if (rst_n && key_ack) begin
            exp_t e;
            ack_seen++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ack ack=1 want=0");
            end else begin
                e = sb.pop_front();
                if (disp_data !== e.disp || entry_count !== e.cnt ||
                    err !== e.err || value !== e.val ||
                    value_valid !== e.vv) begin
                    bad++;
                    $display("FAIL key_result got disp=%h cnt=%0d err=%b val=%h vv=%b want disp=%h cnt=%0d err=%b val=%h vv=%b",
                             disp_data, entry_count, err, value, value_valid,
                             e.disp, e.cnt, e.err, e.val, e.vv);
                end
            end
        end
        if (rst_n && err && !key_ack) begin
            total++;
            bad++;
            $display("FAIL err_without_ack err=1 want=0");
        end
    end

    task automatic push_expect(input logic [3:0] code);
        exp_t e;
        e.err = 1'b0;
        if (code == 4'hE) begin
            if (m_cnt > 0) begin
                m_buf = m_buf >> 4;
                m_cnt--;
            end
        end else if (code == 4'hF) begin
            if (m_cnt > 0) begin
                m_val = m_buf;
                m_vv  = 1'b1;
                m_buf = '0;
                m_cnt = 0;
            end else begin
                e.err = 1'b1;
            end
        end else if (m_cnt < 4) begin
            m_buf = {m_buf[11:0], code};
            m_cnt++;
        end else begin
            e.err = 1'b1;
        end
        e.disp = m_buf;
        e.cnt  = 3'(m_cnt);
        e.val  = m_val;
        e.vv   = m_vv;
        sb.push_back(e);
    endtask

    // Waits for the ack of the key being presented, holds, then releases.
    task automatic wait_ack(input logic [3:0] code, input int hold);
        bit got;
        exp_t e;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = key_ack;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL ack_timeout key=%h ack=0 want=1", code);
            if (sb.size() > 0) e = sb.pop_front();
        end
        repeat (hold) @(negedge clk);
        key_ready = 1'b0;
        @(negedge clk);
        total++;
        if (key_ack !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL pulse_width key=%h ack=%b err=%b want 0 0",
                     code, key_ack, err);
        end
        @(negedge clk);
    endtask

    task automatic press_key(input logic [3:0] code, input int hold);
        push_expect(code);
        key_code  = code;
        key_ready = 1'b1;
        wait_ack(code, hold);
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        key_code    = 4'h0;
        key_ready   = 1'b0;
        value_ready = 1'b0;
        #3;
        total++;
        if (disp_data !== 16'h0 || entry_count !== 3'd0 ||
            value !== 16'h0 || value_valid !== 1'b0 ||
            key_ack !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state disp=%h cnt=%0d val=%h vv=%b ack=%b err=%b want all 0",
                     disp_data, entry_count, value, value_valid, key_ack, err);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_digits;
        press_key(4'h1, 0);
        press_key(4'h2, 0);
        press_key(4'h3, 0);
        press_key(4'h4, 0);
        total++;
        if (disp_data !== 16'h1234 || entry_count !== 3'd4) begin
            bad++;
            $display("FAIL digits disp=%h cnt=%0d want 1234 4",
                     disp_data, entry_count);
        end
    endtask

    task automatic test_full;
        press_key(4'h7, 0);
        total++;
        if (disp_data !== 16'h1234 || entry_count !== 3'd4) begin
            bad++;
            $display("FAIL full_hold disp=%h cnt=%0d want 1234 4",
                     disp_data, entry_count);
        end
    endtask

    task automatic test_backspace;
        for (int i = 0; i < 5; i++) press_key(4'hE, 0);
        press_key(4'h1, 0);
        press_key(4'h2, 0);
        press_key(4'h3, 0);
        press_key(4'hE, 0);
        total++;
        if (disp_data !== 16'h0012 || entry_count !== 3'd2) begin
            bad++;
            $display("FAIL backspace disp=%h cnt=%0d want 0012 2",
                     disp_data, entry_count);
        end
        for (int i = 0; i < 3; i++) press_key(4'hE, 0);
        total++;
        if (disp_data !== 16'h0 || entry_count !== 3'd0) begin
            bad++;
            $display("FAIL backspace_empty disp=%h cnt=%0d want 0 0",
                     disp_data, entry_count);
        end
    endtask

    task automatic test_enter;
        int stray;
        press_key(4'h0, 0);
        press_key(4'hA, 0);
        press_key(4'h5, 0);
        press_key(4'hF, 0);
        total++;
        if (value !== 16'h00A5 || value_valid !== 1'b1 ||
            disp_data !== 16'h0 || entry_count !== 3'd0) begin
            bad++;
            $display("FAIL enter val=%h vv=%b disp=%h cnt=%0d want 00a5 1 0 0",
                     value, value_valid, disp_data, entry_count);
        end
        key_code  = 4'h9;
        key_ready = 1'b1;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (key_ack) stray++;
        end
        total++;
        if (stray != 0 || value !== 16'h00A5 || value_valid !== 1'b1) begin
            bad++;
            $display("FAIL stall acks=%0d val=%h vv=%b want 0 00a5 1",
                     stray, value, value_valid);
        end
        value_ready = 1'b1;
        @(negedge clk);
        value_ready = 1'b0;
        total++;
        if (value_valid !== 1'b0) begin
            bad++;
            $display("FAIL value_clear vv=%b want 0", value_valid);
        end
        m_vv = 1'b0;
        push_expect(4'h9);
        wait_ack(4'h9, 0);
        total++;
        if (disp_data !== 16'h0009 || entry_count !== 3'd1) begin
            bad++;
            $display("FAIL after_stall disp=%h cnt=%0d want 0009 1",
                     disp_data, entry_count);
        end
    endtask

    task automatic test_enter_empty;
        int a0;
        press_key(4'hE, 0);
        a0 = ack_seen;
        press_key(4'hF, 20);
        total++;
        if (ack_seen - a0 != 1 || value_valid !== 1'b0) begin
            bad++;
            $display("FAIL enter_empty acks=%0d vv=%b want 1 0",
                     ack_seen - a0, value_valid);
        end
    endtask

    task automatic test_mid_reset;
        bit got;
        press_key(4'h1, 0);
        push_expect(4'h2);
        key_code  = 4'h2;
        key_ready = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = key_ack;
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (!got || disp_data !== 16'h0 || entry_count !== 3'd0 ||
            value !== 16'h0 || value_valid !== 1'b0 ||
            key_ack !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset got=%b disp=%h cnt=%0d val=%h vv=%b ack=%b err=%b want 1 and all 0",
                     got, disp_data, entry_count, value, value_valid, key_ack, err);
        end
        m_buf = '0;
        m_cnt = 0;
        m_val = '0;
        m_vv  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push_expect(4'h2);
        wait_ack(4'h2, 0);
        total++;
        if (disp_data !== 16'h0002 || entry_count !== 3'd1) begin
            bad++;
            $display("FAIL resume disp=%h cnt=%0d want 0002 1",
                     disp_data, entry_count);
        end
    endtask

    initial begin
        test_reset();
        test_digits();
        test_full();
        test_backspace();
        test_enter();
        test_enter_empty();
        test_mid_reset();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_left size=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
